// File: rtl/ad_trig_pkg.sv
// Shared types and parameter defaults for the ADC trigger generator.
package ad_trig_pkg;
  localparam int NCH_DEF   = 4;
  localparam int CNT_W_DEF = 32;
  localparam int DIV_W_DEF = 16;
  localparam int DLY_W_DEF = 16;
  localparam int PW_DEF    = 2;

  typedef enum logic [1:0] {G_IDLE, G_ARM, G_RUN} gstate_t;
  typedef enum logic [1:0] {CH_WAIT_DLY, CH_SAMPLE, CH_DONE} chstate_t;
endpackage

// File: rtl/ad_trig_ch.sv
// One trigger channel: start delay, D-per-P accumulator pacing, pulse stretcher, sticky errors.
module ad_trig_ch
  import ad_trig_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DLY_W = DLY_W_DEF,
  parameter int PW    = PW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             restart,
  input  logic             err_clr,
  input  logic             ch_en,
  input  logic [DIV_W-1:0] div,
  input  logic [DLY_W-1:0] dly,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] period,
  output logic             ad_start,
  output logic             cfg_err,
  output logic             short_err
);
  localparam int ACC_W = CNT_W + 1;
  localparam int PW_W  = (PW > 1) ? $clog2(PW) : 1;

  chstate_t         st;
  logic [DLY_W-1:0] dly_cnt;
  logic [ACC_W-1:0] acc, acc_sum, period_ext;
  logic [DIV_W-1:0] d_sh, cnt;
  logic [PW_W-1:0]  pw_cnt;
  logic             div_gt_p, silent, issue, last;

  always_comb begin
    acc_sum    = acc + ACC_W'(d_sh);
    period_ext = ACC_W'(period);
    div_gt_p   = CNT_W'(div) > period_in;
    silent     = !ch_en || (div == '0) || (period_in == '0) || div_gt_p;
    last       = (cnt + DIV_W'(1)) == d_sh;
    issue      = 1'b0;
    if (!restart) begin
      case (st)
        CH_WAIT_DLY: issue = (dly_cnt == '0);
        CH_SAMPLE:   issue = (acc_sum >= period_ext);
        default:     issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= CH_DONE;
      dly_cnt  <= '0;
      acc      <= '0;
      d_sh     <= '0;
      cnt      <= '0;
      pw_cnt   <= '0;
      ad_start <= 1'b0;
    end else if (clr) begin
      st       <= CH_DONE;
      dly_cnt  <= '0;
      acc      <= '0;
      d_sh     <= '0;
      cnt      <= '0;
      pw_cnt   <= '0;
      ad_start <= 1'b0;
    end else begin
      if (restart) begin
        st      <= silent ? CH_DONE : CH_WAIT_DLY;
        dly_cnt <= dly;
        acc     <= '0;
        cnt     <= '0;
        d_sh    <= div;
      end else begin
        case (st)
          CH_WAIT_DLY: begin
            if (issue) begin
              acc <= '0;
              cnt <= cnt + DIV_W'(1);
              st  <= last ? CH_DONE : CH_SAMPLE;
            end else begin
              dly_cnt <= dly_cnt - DLY_W'(1);
            end
          end
          CH_SAMPLE: begin
            // remainder carries over so sample k lands at ceil(k*P/D)
            if (issue) begin
              acc <= acc_sum - period_ext;
              cnt <= cnt + DIV_W'(1);
              if (last) st <= CH_DONE;
            end else begin
              acc <= acc_sum;
            end
          end
          default: ;
        endcase
      end
      // a new sample reloads the width counter, so close samples merge
      if (issue) begin
        ad_start <= 1'b1;
        pw_cnt   <= PW_W'(PW - 1);
      end else if (pw_cnt != '0) begin
        pw_cnt <= pw_cnt - PW_W'(1);
      end else begin
        ad_start <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err   <= 1'b0;
      short_err <= 1'b0;
    end else begin
      if (err_clr) begin
        cfg_err   <= 1'b0;
        short_err <= 1'b0;
      end
      if (restart && !clr) begin
        if (div_gt_p)       cfg_err   <= 1'b1;
        if (st != CH_DONE)  short_err <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ad_trig_gen.sv
// Phase-locked ADC trigger generator: global IDLE/ARM/RUN control and NCH paced channels.
module ad_trig_gen
  import ad_trig_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DLY_W = DLY_W_DEF,
  parameter int PW    = PW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 phase_valid,
  input  logic [CNT_W-1:0]     phase_period,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH*DIV_W-1:0] ch_div,
  input  logic [NCH*DLY_W-1:0] ch_dly,
  input  logic                 err_clr,
  output logic [NCH-1:0]       ad_start,
  output logic                 running,
  output logic [NCH-1:0]       cfg_err,
  output logic [NCH-1:0]       short_err
);
  gstate_t          gst;
  logic [CNT_W-1:0] p_sh;
  logic             restart;

  assign restart = en && phase_valid && (gst != G_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gst     <= G_IDLE;
      running <= 1'b0;
      p_sh    <= '0;
    end else if (!en) begin
      gst     <= G_IDLE;
      running <= 1'b0;
      p_sh    <= '0;
    end else begin
      case (gst)
        G_IDLE: gst <= G_ARM;
        G_ARM: begin
          if (phase_valid) begin
            gst     <= G_RUN;
            running <= 1'b1;
          end
        end
        default: ;
      endcase
      if (restart) p_sh <= phase_period;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ad_trig_ch #(
      .CNT_W(CNT_W),
      .DIV_W(DIV_W),
      .DLY_W(DLY_W),
      .PW   (PW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (!en),
      .restart  (restart),
      .err_clr  (err_clr),
      .ch_en    (ch_en[i]),
      .div      (ch_div[i*DIV_W +: DIV_W]),
      .dly      (ch_dly[i*DLY_W +: DLY_W]),
      .period_in(phase_period),
      .period   (p_sh),
      .ad_start (ad_start[i]),
      .cfg_err  (cfg_err[i]),
      .short_err(short_err[i])
    );
  end
endmodule

// File: tb/tb_ad_trig_gen.sv
// Bench for ad_trig_gen (NCH=8): directed vector table, en/reset sequences, random vs. schedule model.
module tb_ad_trig_gen;
  localparam int NCH = 8, CNT_W = 32, DIV_W = 16, DLY_W = 16, PW = 2;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, phase_valid = 1'b0, err_clr = 1'b0;
  logic [CNT_W-1:0]     phase_period = '0;
  logic [NCH-1:0]       ch_en = '0;
  logic [NCH*DIV_W-1:0] ch_div = '0;
  logic [NCH*DLY_W-1:0] ch_dly = '0;
  logic [NCH-1:0]       ad_start, cfg_err, short_err;
  logic                 running;

  ad_trig_gen #(.NCH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W), .DLY_W(DLY_W), .PW(PW)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_valid(phase_valid), .phase_period(phase_period),
    .ch_en(ch_en), .ch_div(ch_div), .ch_dly(ch_dly), .err_clr(err_clr),
    .ad_start(ad_start), .running(running), .cfg_err(cfg_err), .short_err(short_err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  longint cyc = 0;

  // Model: each restart turns the latched config into a list of absolute sample edges.
  int m_mode;  // 0 idle, 1 armed, 2 running
  longint sched[NCH][$];
  longint hi_until[NCH];
  logic [NCH-1:0] m_cfg, m_sh;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    for (int i = 0; i < NCH; i++) begin
      sched[i].delete();
      hi_until[i] = 0;
    end
    m_cfg = '0;
    m_sh  = '0;
  endtask

  task automatic model_step(input longint c);
    logic [NCH-1:0] set_cfg, set_sh;
    longint d, dl, p;
    set_cfg = '0;
    set_sh  = '0;
    if (!en) begin
      m_mode = 0;
      for (int i = 0; i < NCH; i++) begin
        sched[i].delete();
        hi_until[i] = 0;
      end
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (phase_valid) begin
      m_mode = 2;
      p = longint'(phase_period);
      for (int i = 0; i < NCH; i++) begin
        d  = longint'(ch_div[i*DIV_W +: DIV_W]);
        dl = longint'(ch_dly[i*DLY_W +: DLY_W]);
        if (sched[i].size() != 0) set_sh[i] = 1'b1;
        sched[i].delete();
        if (d > p) set_cfg[i] = 1'b1;
        if (ch_en[i] && d != 0 && p != 0 && d <= p)
          for (longint k = 0; k < d; k++) sched[i].push_back(c + 1 + dl + (k * p + d - 1) / d);
      end
    end else begin
      for (int i = 0; i < NCH; i++)
        if (sched[i].size() != 0 && sched[i][0] == c) begin
          void'(sched[i].pop_front());
          hi_until[i] = c + PW;
        end
    end
    if (err_clr) begin
      m_cfg = '0;
      m_sh  = '0;
    end
    m_cfg |= set_cfg;
    m_sh  |= set_sh;
  endtask

  task automatic step();
    logic [NCH-1:0] exp_ad;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) model_reset();
    else model_step(cyc);
    for (int i = 0; i < NCH; i++) exp_ad[i] = (cyc < hi_until[i]);
    chk($sformatf("cyc%0d", cyc), {ad_start, running, cfg_err, short_err},
        {exp_ad, (m_mode == 2), m_cfg, m_sh});
  endtask

  task automatic set_ch0(input int p, input int d, input int dly);
    phase_period = CNT_W'(p);
    ch_div = '0;
    ch_div[DIV_W-1:0] = DIV_W'(d);
    ch_dly = '0;
    ch_dly[DLY_W-1:0] = DLY_W'(dly);
    ch_en = '1;
  endtask

  task automatic randomize_cfg();
    phase_period = ($urandom_range(0, 19) == 0) ? '0 : CNT_W'($urandom_range(1, 40));
    for (int i = 0; i < NCH; i++) begin
      ch_div[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 14));
      ch_dly[i*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 8));
    end
    ch_en = NCH'($urandom);
  endtask

  typedef struct {
    int p; int d; int dly; int pv2; int run_len; int nrise;
    int r0; int r1; int r2; int r3; int r4;
    logic sh; logic cfg;
  } vec_t;

  initial begin
    vec_t vt[6];
    int rec[8];
    int er[5];
    int nrec, gap;
    longint t0;
    logic prev, any;

    vt[0] = '{1000, 4, 0, 1000, 1010, 5, 1, 251, 501, 751, 1001, 1'b0, 1'b0};
    vt[1] = '{10,   3, 2, 0,    40,   3, 3, 7,   10,  0,   0,    1'b0, 1'b0};
    vt[2] = '{1000, 4, 0, 600,  700,  4, 1, 251, 501, 601, 0,    1'b1, 1'b0};
    vt[3] = '{4,    6, 0, 0,    20,   0, 0, 0,   0,   0,   0,    1'b0, 1'b1};
    vt[4] = '{7,    7, 1, 0,    20,   1, 2, 0,   0,   0,   0,    1'b0, 1'b0};
    vt[5] = '{5,    1, 3, 0,    20,   1, 4, 0,   0,   0,   0,    1'b0, 1'b0};

    model_reset();
    step();
    step();
    chk("reset outputs", {ad_start, running, cfg_err, short_err}, '0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      set_ch0(vt[v].p, vt[v].d, vt[v].dly);
      en = 1'b0; err_clr = 1'b1; step();
      err_clr = 1'b0; en = 1'b1; step();
      phase_valid = 1'b1; step();
      phase_valid = 1'b0;
      t0 = cyc; prev = 1'b0; nrec = 0;
      for (int n = 1; n <= vt[v].run_len; n++) begin
        phase_valid = (n == vt[v].pv2);
        step();
        if (ad_start[0] && !prev) begin
          if (nrec < 8) rec[nrec] = int'(cyc - t0);
          nrec++;
        end
        prev = ad_start[0];
      end
      phase_valid = 1'b0;
      er = '{vt[v].r0, vt[v].r1, vt[v].r2, vt[v].r3, vt[v].r4};
      chk($sformatf("v%0d rise count", v), nrec, vt[v].nrise);
      for (int j = 0; j < vt[v].nrise && j < nrec; j++)
        chk($sformatf("v%0d rise%0d", v, j), rec[j], er[j]);
      chk($sformatf("v%0d short_err", v), short_err[0], vt[v].sh);
      chk($sformatf("v%0d cfg_err", v), cfg_err[0], vt[v].cfg);
      chk($sformatf("v%0d d0 chan errs", v), {short_err[1], cfg_err[1]}, 2'b00);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk($sformatf("v%0d err_clr", v), {short_err, cfg_err}, '0);
    end

    // en dropped in the middle of a pulse
    set_ch0(100, 4, 0);
    en = 1'b0; step();
    en = 1'b1; step();
    phase_valid = 1'b1; step(); phase_valid = 1'b0;
    step();
    chk("en pulse high", ad_start[0], 1'b1);
    en = 1'b0; step();
    chk("en drop ad_start", ad_start, '0);
    chk("en drop running", running, 1'b0);
    en = 1'b1; any = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      any |= |ad_start;
    end
    chk("no sample before pv", any, 1'b0);
    phase_valid = 1'b1; step(); phase_valid = 1'b0;
    step();
    chk("sample after pv", ad_start[0], 1'b1);

    // asynchronous reset mid-run, with a cfg error pending
    set_ch0(20, 4, 0);
    ch_div[2*DIV_W +: DIV_W] = DIV_W'(30);
    phase_valid = 1'b1; step(); phase_valid = 1'b0;
    step();
    chk("pre-reset state", {ad_start[0], running, cfg_err[2]}, 3'b111);
    #3 rst_n = 1'b0;
    #1 chk("async reset", {ad_start, running, cfg_err, short_err}, '0);
    model_reset();
    #1 rst_n = 1'b1;
    any = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      any |= |ad_start;
    end
    chk("silent after reset", any, 1'b0);
    phase_valid = 1'b1; step(); phase_valid = 1'b0;
    step();
    chk("first sample after reset", ad_start[0], 1'b1);

    // random configs, strobes, enables and clears against the model
    gap = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) randomize_cfg();
      err_clr = ($urandom_range(0, 49) == 0);
      if (!en) en = ($urandom_range(0, 3) == 0);
      else en = ($urandom_range(0, 299) != 0);
      if (gap == 0) begin
        phase_valid = 1'b1;
        gap = $urandom_range(2, 60);
      end else begin
        phase_valid = 1'b0;
        gap--;
      end
      step();
    end
    phase_valid = 1'b0;
    err_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ad_trig_gen.md
AD_TRIG_GEN -- requirements
Module: ad_trig_gen

Interface
REQ-001 SHALL have parameter NCH, default 4: number of ADC trigger channels.
REQ-002 SHALL have parameter CNT_W, default 32: phase-period width in clk cycles.
REQ-003 SHALL have parameter DIV_W, default 16: samples-per-period divisor width; DIV_W <= CNT_W.
REQ-004 SHALL have parameter DLY_W, default 16: per-channel start-delay width.
REQ-005 SHALL have parameter PW, default 2: ad_start pulse width in clk cycles, PW >= 1.
REQ-006 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port en  in  1  global enable; level.
REQ-009 SHALL have port phase_valid  in  1  one-cycle strobe marking the phase reference edge.
REQ-010 SHALL have port phase_period  in  CNT_W  measured clk cycles per phase period; sampled on phase_valid.
REQ-011 SHALL have port ch_en  in  NCH  per-channel enable.
REQ-012 SHALL have port ch_div  in  NCH*DIV_W  samples per phase period, channel i at bits [i*DIV_W +: DIV_W].
REQ-013 SHALL have port ch_dly  in  NCH*DLY_W  cycles from phase edge to first sample, packed the same way.
REQ-014 SHALL have port err_clr  in  1  one-cycle clear of all sticky error flags.
REQ-015 SHALL have port ad_start  out  NCH  ADC conversion trigger pulses.
REQ-016 SHALL have port running  out  1  high while the global FSM is in RUN.
REQ-017 SHALL have port cfg_err  out  NCH  sticky: divisor > latched period.
REQ-018 SHALL have port short_err  out  NCH  sticky: phase_valid arrived before the channel issued all ch_div samples.

Function
REQ-019 SHALL implement global FSM IDLE->ARM on en=1; ARM->RUN on phase_valid; any state->IDLE on en=0.
REQ-020 SHALL, on every phase_valid in ARM or RUN, shadow phase_period, ch_div, ch_dly and ch_en, and restart all channels; register changes between strobes have no effect.
REQ-021 SHALL implement per-channel states WAIT_DLY, SAMPLE, DONE; restart enters WAIT_DLY with delay counter = ch_dly, accumulator = 0, sample count = 0.
REQ-022 SHALL move WAIT_DLY->SAMPLE once the delay count expires; with phase_valid at cycle 0, the first ad_start rises at cycle 1+dly.
REQ-023 SHALL, in SAMPLE, add D to a CNT_W+1-bit accumulator each cycle; when acc+D >= P, issue a sample and store acc+D-P; sample k rises at cycle 1+dly+ceil(k*P/D).
REQ-024 SHALL stop after D samples (DONE) until the next phase_valid; no divider or multiplier is permitted.
REQ-025 SHALL drive ad_start[i] high for PW cycles per sample; a sample issued while the pulse is active reloads the width counter (pulses merge, no error).
REQ-026 SHALL keep a channel silent for the period when its shadowed ch_en=0, D=0 or P=0.
REQ-027 SHALL, when D > P at latch, keep the channel silent and set cfg_err[i].
REQ-028 SHALL set short_err[i] when phase_valid arrives in WAIT_DLY or SAMPLE of a channel with D>0 and ch_en=1; the restart still occurs that cycle.
REQ-029 SHALL give set priority over err_clr when both occur in the same cycle.
REQ-030 SHALL, on en=0, force ad_start low on the next cycle and clear all channel state; sticky flags are kept.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously set FSM=IDLE, ad_start=0, running=0, cfg_err=0, short_err=0, and clear all counters, accumulators and shadows.
REQ-032 SHALL require a fresh phase_valid after reset release before any ad_start is issued.

Structure
REQ-033 SHALL place the global and channel state enums and the parameter defaults in package ad_trig_pkg.
REQ-034 SHALL implement each channel (delay counter, accumulator, sample count, pulse stretcher, error flags) as sub-module ad_trig_ch, generated NCH times.

Verification
REQ-035 SHALL cover: P=1000, D=4, dly=0, PW=2, phase_valid at cycles 0 and 1000 -> ad_start rises at 1, 251, 501, 751, 1001; no errors.
REQ-036 SHALL cover: P=10, D=3, dly=2 -> rises at 3, 7, 10; then silent until the next phase_valid.
REQ-037 SHALL cover: P=1000, D=4, early phase_valid at 600 -> rises at 1, 251, 501, 601; short_err=1; err_clr clears it.
REQ-038 SHALL cover: P=4, D=6 -> channel silent, cfg_err=1; D=0 channel silent, no error.
REQ-039 SHALL cover: en dropped mid-pulse -> ad_start=0 next cycle, running=0; a sample is issued only after en=1 and a new phase_valid.
REQ-040 SHALL cover: rst_n asserted mid-run -> all outputs 0 immediately; NCH=8 build exercised.
